dfm_ctrl: RTL and testbench

DFM_CTRL -- requirements
Module: dfm_ctrl

---
 rtl/dfm_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dfm_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfm_ctrl.sv
// dfm_ctrl: sequences a frequency-measure datapath. A run discards the first
// (partial-gate) result, then accumulates N ref/signal count pairs into 40-bit
// sums and presents them through a valid/ready result port. A watchdog ends the
// run early, with a timeout flag, if the datapath goes silent for too long.
//
// Result handshake: res_valid_o rises when a run completes and then holds, with
// every res_* output stable, until a cycle where res_valid_o && res_ready_i;
// the result is consumed on that edge and the block is back in IDLE after it.
module dfm_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_start_i,
    input  logic        cfg_stop_i,
    input  logic [7:0]  cfg_avg_num_i,
    input  logic [31:0] cfg_gate_time_i,
    output logic        meas_en_o,
    output logic [31:0] meas_gate_time_o,
    input  logic        meas_wr_en_i,
    input  logic [63:0] meas_wr_data_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [39:0] res_ref_sum_o,
    output logic [39:0] res_sig_sum_o,
    output logic [7:0]  res_num_o,
    output logic        res_timeout_o,
    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISCARD = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        meas_en_q, meas_en_d;
    logic        res_valid_q, res_valid_d;

    logic [7:0]  n_q, n_d;
    logic [31:0] gate_q, gate_d;
    logic [39:0] acc_ref_q, acc_ref_d;
    logic [39:0] acc_sig_q, acc_sig_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [39:0] res_ref_q, res_ref_d;
    logic [39:0] res_sig_q, res_sig_d;
    logic [7:0]  res_num_q, res_num_d;
    logic        res_to_q, res_to_d;

    logic        to_hit;
    logic        last_sample;

    // Watchdog expiry: silence has lasted the full allowed window this cycle.
    assign to_hit      = (to_cnt_q == (TIMEOUT_CYCLES - 32'd1));
    // The strobe in RUN that completes the requested number of results.
    assign last_sample = meas_wr_en_i && ((cnt_q + 8'd1) == n_q);

    // State register plus the registered enable/valid outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            meas_en_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            meas_en_q   <= meas_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state: stop beats strobe, strobe beats watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (cfg_stop_i)        state_d = S_IDLE;
                else if (meas_wr_en_i) state_d = S_RUN;
                else if (to_hit)       state_d = S_DONE;
            end
            S_RUN: begin
                if (cfg_stop_i)        state_d = S_IDLE;
                else if (last_sample)  state_d = S_DONE;
                else if (!meas_wr_en_i && to_hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track it.
    always_comb begin
        meas_en_d   = (state_d == S_DISCARD) || (state_d == S_RUN);
        res_valid_d = (state_d == S_DONE);
    end

    // Datapath next values: run setup, accumulation, watchdog, result capture.
    always_comb begin
        n_d       = n_q;
        gate_d    = gate_q;
        acc_ref_d = acc_ref_q;
        acc_sig_d = acc_sig_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        res_ref_d = res_ref_q;
        res_sig_d = res_sig_q;
        res_num_d = res_num_q;
        res_to_d  = res_to_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    n_d       = (cfg_avg_num_i == 8'd0) ? 8'd1 : cfg_avg_num_i;
                    gate_d    = cfg_gate_time_i;
                    acc_ref_d = 40'd0;
                    acc_sig_d = 40'd0;
                    cnt_d     = 8'd0;
                    to_cnt_d  = 32'd0;
                end
            end
            S_DISCARD, S_RUN: begin
                if (!cfg_stop_i) begin
                    if (meas_wr_en_i) begin
                        to_cnt_d = 32'd0;
                        // The DISCARD strobe carries a partial gate and is dropped.
                        if (state_q == S_RUN) begin
                            acc_ref_d = acc_ref_q + {8'd0, meas_wr_data_i[63:32]};
                            acc_sig_d = acc_sig_q + {8'd0, meas_wr_data_i[31:0]};
                            cnt_d     = cnt_q + 8'd1;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
        // Results change only when a run completes, so they hold everywhere else.
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            res_ref_d = acc_ref_d;
            res_sig_d = acc_sig_d;
            res_num_d = cnt_d;
            res_to_d  = !meas_wr_en_i;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_q       <= 8'd0;
            gate_q    <= 32'd0;
            acc_ref_q <= 40'd0;
            acc_sig_q <= 40'd0;
            cnt_q     <= 8'd0;
            to_cnt_q  <= 32'd0;
            res_ref_q <= 40'd0;
            res_sig_q <= 40'd0;
            res_num_q <= 8'd0;
            res_to_q  <= 1'b0;
        end else begin
            n_q       <= n_d;
            gate_q    <= gate_d;
            acc_ref_q <= acc_ref_d;
            acc_sig_q <= acc_sig_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            res_ref_q <= res_ref_d;
            res_sig_q <= res_sig_d;
            res_num_q <= res_num_d;
            res_to_q  <= res_to_d;
        end
    end

    assign meas_en_o        = meas_en_q;
    assign meas_gate_time_o = gate_q;
    assign res_valid_o      = res_valid_q;
    assign res_ref_sum_o    = res_ref_q;
    assign res_sig_sum_o    = res_sig_q;
    assign res_num_o        = res_num_q;
    assign res_timeout_o    = res_to_q;
    assign busy_o           = (state_q != S_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dfm_ctrl.sv
// Bench for dfm_ctrl. A run is described as a list of (edge time, data)
// strobes; the reference model derives the expected result from the rules:
// drop the first strobe, sum the rest until N, or stop after TO idle edges.
module tb_dfm_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_stop;
    logic [7:0]  cfg_avg_num;
    logic [31:0] cfg_gate_time;
    logic        meas_en;
    logic [31:0] meas_gate_time;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        res_valid, res_ready;
    logic [39:0] res_ref, res_sig;
    logic [7:0]  res_num;
    logic        res_to, busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe schedule for the current run (times are edges after the start edge).
    int          s_time[$];
    logic [63:0] s_data[$];

    // Model outputs.
    logic [39:0] e_ref, e_sig;
    logic [7:0]  e_num;
    logic        e_to;
    int          e_done_t;

    // Last presented result (outputs must hold it outside DONE).
    logic [39:0] p_ref = '0, p_sig = '0;
    logic [7:0]  p_num = '0;
    logic        p_to  = 1'b0;

    dfm_ctrl #(.TIMEOUT_CYCLES(32'(TO))) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
        .cfg_avg_num_i(cfg_avg_num), .cfg_gate_time_i(cfg_gate_time),
        .meas_en_o(meas_en), .meas_gate_time_o(meas_gate_time),
        .meas_wr_en_i(wr_en), .meas_wr_data_i(wr_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_ref_sum_o(res_ref), .res_sig_sum_o(res_sig),
        .res_num_o(res_num), .res_timeout_o(res_to),
        .busy_o(busy), .dbg_state_o(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_ref_hold"}, res_ref, p_ref);
        chk({tag, "_sig_hold"}, res_sig, p_sig);
        chk({tag, "_num_hold"}, res_num, p_num);
        chk({tag, "_to_hold"},  res_to,  p_to);
    endtask

    // Reference model: walk the strobes in time order.
    task automatic model(input logic [7:0] n);
        int last, cnt, need;
        bit first, done;
        last = 0; cnt = 0; first = 1; done = 0;
        need = (n == 0) ? 1 : int'(n);
        e_ref = '0; e_sig = '0; e_to = 0; e_done_t = 0;
        foreach (s_time[i]) begin
            if (done) break;
            if (s_time[i] - last > TO) begin
                done = 1; e_to = 1; e_done_t = last + TO;
            end else begin
                last = s_time[i];
                if (first) first = 0;
                else begin
                    e_ref += 40'(s_data[i][63:32]);
                    e_sig += 40'(s_data[i][31:0]);
                    cnt++;
                    if (cnt == need) begin done = 1; e_done_t = s_time[i]; end
                end
            end
        end
        if (!done) begin e_to = 1; e_done_t = last + TO; end
        e_num = 8'(cnt);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Start a run, play the schedule, check the result and the handshake.
    task automatic run_sched(input logic [7:0] n, input int hold, input bit with_stop);
        int idx;
        logic [31:0] gate;
        gate = $urandom;
        model(n);
        cfg_avg_num = n; cfg_gate_time = gate; cfg_start = 1; cfg_stop = with_stop;
        step;
        cfg_start = 0; cfg_stop = 0; cfg_gate_time = $urandom;
        chk("start_meas_en", meas_en, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("gate_latched", meas_gate_time, gate);
        idx = 0;
        for (int t = 1; t <= e_done_t; t++) begin
            wr_en = 0; wr_data = {$urandom, $urandom};
            if (idx < s_time.size() && s_time[idx] == t) begin
                wr_en = 1; wr_data = s_data[idx]; idx++;
            end
            cfg_start = ($urandom_range(0, 7) == 0);
            step;
            wr_en = 0; cfg_start = 0;
            if (t < e_done_t) begin
                chk("run_valid_low", res_valid, 1'b0);
                chk("run_meas_en", meas_en, 1'b1);
                chk("run_res_hold", res_ref, p_ref);
            end
        end
        chk("done_valid", res_valid, 1'b1);
        chk("done_ref", res_ref, e_ref);
        chk("done_sig", res_sig, e_sig);
        chk("done_num", res_num, e_num);
        chk("done_timeout", res_to, e_to);
        chk("done_meas_en", meas_en, 1'b0);
        chk("done_busy", busy, 1'b1);
        p_ref = e_ref; p_sig = e_sig; p_num = e_num; p_to = e_to;
        for (int k = 0; k < hold; k++) begin
            res_ready = 0;
            wr_en = $urandom_range(0, 1); wr_data = {$urandom, $urandom};
            cfg_start = $urandom_range(0, 1); cfg_stop = $urandom_range(0, 1);
            step;
            wr_en = 0; cfg_start = 0; cfg_stop = 0;
            chk("wait_valid", res_valid, 1'b1);
            chk("wait_meas_en", meas_en, 1'b0);
            chk_hold("wait");
        end
        res_ready = 1;
        step;
        res_ready = 0;
        chk("hs_busy", busy, 1'b0);
        chk("hs_valid", res_valid, 1'b0);
        chk_hold("hs");
        s_time.delete(); s_data.delete();
    endtask

    task automatic add_strobe(input int t, input logic [63:0] d);
        s_time.push_back(t); s_data.push_back(d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_valid"}, res_valid, 1'b0);
        chk({tag, "_meas_en"}, meas_en, 1'b0);
        chk({tag, "_gate"}, meas_gate_time, 32'd0);
        chk({tag, "_ref"}, res_ref, 40'd0);
        chk({tag, "_sig"}, res_sig, 40'd0);
        chk({tag, "_num"}, res_num, 8'd0);
        chk({tag, "_to"}, res_to, 1'b0);
    endtask

    initial begin
        int t, cnt, inj, neff;
        rst_n = 0; cfg_start = 0; cfg_stop = 0; cfg_avg_num = 0; cfg_gate_time = 0;
        wr_en = 0; wr_data = 0; res_ready = 0;
        #12;
        chk_reset_outputs("reset");
        rst_n = 1;
        step;

        // Two-sample average with a dropped first result.
        add_strobe(2, 64'h64_0000_000A);
        add_strobe(4, 64'h64_0000_000A);
        add_strobe(5, 64'h65_0000_000B);
        run_sched(8'd2, 2, 0);

        // N of zero behaves as one; start with stop in IDLE still starts.
        add_strobe(1, 64'h64_0000_000A);
        add_strobe(3, 64'h10_0000_0003);
        run_sched(8'd0, 0, 1);

        // Silence after the dropped strobe: watchdog ends the run empty.
        add_strobe(1, 64'h64_0000_000A);
        run_sched(8'd4, 10, 0);

        // Strobe exactly on the watchdog edge wins over the timeout.
        add_strobe(TO, 64'h1_0000_0001);
        add_strobe(2 * TO, 64'h2_0000_0002);
        add_strobe(3 * TO, 64'h3_0000_0003);
        run_sched(8'd2, 1, 0);

        // Largest run with full-scale data: sums must not wrap.
        for (int i = 1; i <= 256; i++) add_strobe(i, 64'hFFFF_FFFF_FFFF_FFFF);
        run_sched(8'd255, 0, 0);

        // Stop coincident with a RUN strobe aborts with no result.
        cfg_avg_num = 8'd3; cfg_gate_time = $urandom; cfg_start = 1;
        step;
        cfg_start = 0;
        wr_en = 1; wr_data = 64'h5_0000_0005;
        step;
        cfg_stop = 1;
        step;
        wr_en = 0; cfg_stop = 0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_meas_en", meas_en, 1'b0);
        for (int k = 0; k < 20; k++) begin
            wr_en = $urandom_range(0, 1); wr_data = {$urandom, $urandom};
            step;
            chk("stop_no_valid", res_valid, 1'b0);
        end
        wr_en = 0;
        chk_hold("stop");

        // Asynchronous reset in the middle of RUN.
        cfg_avg_num = 8'd5; cfg_start = 1;
        step;
        cfg_start = 0;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1; wr_data = {$urandom, $urandom};
            step;
        end
        wr_en = 0;
        #2 rst_n = 0;
        #1;
        chk_reset_outputs("async_rst");
        #3 rst_n = 1;
        p_ref = '0; p_sig = '0; p_num = '0; p_to = 0;
        for (int k = 0; k < 2 * TO + 4; k++) begin
            wr_en = $urandom_range(0, 1); wr_data = {$urandom, $urandom};
            step;
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_valid", res_valid, 1'b0);
        end
        wr_en = 0;

        // Randomized runs, some with a gap long enough to trip the watchdog.
        for (int r = 0; r < 30; r++) begin
            cfg_avg_num = 8'($urandom_range(0, 6));
            neff = (cfg_avg_num == 0) ? 1 : int'(cfg_avg_num);
            cnt = neff + 1;
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            t = 0;
            for (int i = 0; i < cnt; i++) begin
                t += (i == inj) ? int'($urandom_range(TO + 1, TO + 4)) : int'($urandom_range(1, TO));
                add_strobe(t, ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                          : {$urandom, $urandom});
            end
            run_sched(cfg_avg_num, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
